// File: rtl/register_pkg.sv
// Shared datapath constants for the generic enable register.
package register_pkg;

  // Datapath width used across the CPU; default width of the register.
  localparam int unsigned DATA_WIDTH = 32;

endpackage : register_pkg

// File: rtl/register.sv
// Enable-gated data register with synchronous active-high reset.
// Captures d when en is high; reset takes priority over load.
// q is driven straight from the storage flops.
module register
  import register_pkg::*;
#(
  parameter int unsigned             WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             en
);

  // Storage starts at RESET_VALUE in simulation; hardware still needs a reset.
  logic [WIDTH-1:0] data_q = RESET_VALUE;
  logic [WIDTH-1:0] data_d;

  // Next-state selection: reset, then load, else hold.
  always_comb begin
    data_d = data_q;
    if (rst) begin
      data_d = RESET_VALUE;
    end else if (en) begin
      data_d = d;
    end
  end

  // Single state update on the rising edge.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule : register

// File: tb/tb_register.sv
// Directed self-checking bench for register: default 32-bit instance and
// an 8-bit instance with a non-zero reset value.
module tb_register;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] d;
  logic [31:0] q;

  logic        rst8;
  logic        en8;
  logic [7:0]  d8;
  logic [7:0]  q8;

  int unsigned n_tests;
  int unsigned n_fail;

  register dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q),
    .en  (en)
  );

  register #(
    .WIDTH       (8),
    .RESET_VALUE (8'h7F)
  ) dut8 (
    .clk (clk),
    .rst (rst8),
    .d   (d8),
    .q   (q8),
    .en  (en8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] expected);
    n_tests++;
    assert (q === expected) else begin
      n_fail++;
      $error("FAIL %s: q observed %h expected %h", tag, q, expected);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] expected);
    n_tests++;
    assert (q8 === expected) else begin
      n_fail++;
      $error("FAIL %s: q8 observed %h expected %h", tag, q8, expected);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    rst  = 1'b1;
    en   = 1'b1;
    d    = 32'hDEADBEEF;
    rst8 = 1'b1;
    en8  = 1'b1;
    d8   = 8'hAA;
    #1;
    check32("powerup32", 32'h0000_0000);
    check8("powerup8", 8'h7F);

    // Reset for two edges with en=1 and live data
    tick();
    check32("reset_edge1", 32'h0000_0000);
    check8("reset8", 8'h7F);
    tick();
    check32("reset_edge2", 32'h0000_0000);

    // Single load; not visible before the edge
    rst = 1'b0;
    en  = 1'b1;
    d   = 32'h0000_0022;
    #1;
    check32("load_before_edge", 32'h0000_0000);
    tick();
    check32("load", 32'h0000_0022);

    // Hold with toggling data
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h1234_5678;
      tick();
      check32("hold", 32'h0000_0022);
    end

    // X on d while disabled
    d = 'x;
    tick();
    check32("hold_x", 32'h0000_0022);

    // Continuous enable: one-cycle follow
    en = 1'b1;
    d = 32'd1; tick(); check32("follow1", 32'd1);
    d = 32'd2; tick(); check32("follow2", 32'd2);
    d = 32'd3; tick(); check32("follow3", 32'd3);
    d = 32'd4; tick(); check32("follow4", 32'd4);

    // Reset priority over simultaneous load
    d = 32'hA5A5_A5A5; tick(); check32("pre_prio", 32'hA5A5_A5A5);
    rst = 1'b1;
    d   = 32'h5A5A_5A5A;
    tick();
    check32("reset_priority", 32'h0000_0000);
    rst = 1'b0;
    tick();
    check32("load_after_reset", 32'h5A5A_5A5A);

    // Reset mid-hold, then stays at reset value until next load
    en  = 1'b0;
    d   = 32'h1111_1111;
    tick();
    check32("hold_pre_reset", 32'h5A5A_5A5A);
    rst = 1'b1;
    tick();
    check32("reset_mid_hold", 32'h0000_0000);
    rst = 1'b0;
    tick();
    check32("post_reset_hold1", 32'h0000_0000);
    tick();
    check32("post_reset_hold2", 32'h0000_0000);
    en = 1'b1;
    d  = 32'hCAFE_F00D;
    tick();
    check32("post_reset_load", 32'hCAFE_F00D);

    // 8-bit instance with RESET_VALUE 7F
    rst8 = 1'b0;
    en8  = 1'b1;
    d8   = 8'h3C;
    tick();
    check8("load8", 8'h3C);
    en8 = 1'b0;
    d8  = 8'hFF;
    tick();
    check8("hold8", 8'h3C);
    rst8 = 1'b1;
    en8  = 1'b1;
    tick();
    check8("reset8_priority", 8'h7F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_register
